lvds_tx: RTL and testbench

- Transmit counterpart of the LVDS receive deserializer.
- Pulls 32-bit I/Q sample words from the TX FIFO and serializes each into a 16-dibit frame on a 2-bit data bus. The bus feeds the DDR output cell driving the modem's LVDS TX pair.
- Frame format is bit-exact with what the receive-side frame decoder expects, so FPGA-internal loopback reproduces the payload.

---
 rtl/lvds_pkg.sv | 37 +++
 rtl/lvds_tx_if.sv | 20 ++
 rtl/lvds_tx_serializer.sv | 29 ++
 rtl/lvds_tx.sv | 107 ++++++++++
 tb/tb_lvds_tx.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_pkg.sv
// Shared LVDS definitions: frame constants, FSM states, dibit selection helper.
package lvds_pkg;

  localparam logic [1:0]  SYNC_I       = 2'b10;
  localparam logic [1:0]  SYNC_Q       = 2'b01;
  localparam logic [1:0]  IDLE_DIBIT   = 2'b00;
  localparam int unsigned FRAME_DIBITS = 16;
  localparam int unsigned SAMPLE_BITS  = 14;
  localparam int unsigned CNT_W        = $clog2(FRAME_DIBITS);

  typedef logic [CNT_W-1:0] dibit_idx_t;

  localparam dibit_idx_t SYNC_I_IDX = dibit_idx_t'(0);
  localparam dibit_idx_t SYNC_Q_IDX = dibit_idx_t'(FRAME_DIBITS / 2);
  localparam dibit_idx_t LAST_IDX   = dibit_idx_t'(FRAME_DIBITS - 1);
  // Pull decision is registered, so it is taken one dibit before the pull is visible.
  localparam dibit_idx_t PULL_IDX   = dibit_idx_t'(FRAME_DIBITS - 3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TX   = 2'd2
  } lvds_state_t;

  // word[31:30] and word[15:14] sit exactly under dibits 0 and 8, so a single
  // left shift by 2*idx lines up every payload dibit; the sync slots override.
  function automatic logic [1:0] frame_dibit(input logic [31:0] word, input dibit_idx_t idx);
    logic [31:0] aligned;
    logic [1:0]  result;
    aligned = word << {idx, 1'b0};
    result  = aligned[31:30];
    if (idx == SYNC_I_IDX) result = SYNC_I;
    if (idx == SYNC_Q_IDX) result = SYNC_Q;
    return result;
  endfunction

endpackage

// File: rtl/lvds_tx_if.sv
// TX FIFO handshake and DDR output bus of the LVDS transmitter.
interface lvds_tx_if;
  logic        i_enable;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_data;
  logic        o_fifo_pull;
  logic [1:0]  o_ddr_data;
  logic        o_busy;
  logic        o_underrun;

  modport master (
    output i_enable, i_fifo_empty, i_fifo_data,
    input  o_fifo_pull, o_ddr_data, o_busy, o_underrun
  );

  modport slave (
    input  i_enable, i_fifo_empty, i_fifo_data,
    output o_fifo_pull, o_ddr_data, o_busy, o_underrun
  );
endinterface

// File: rtl/lvds_tx_serializer.sv
// Sample word holding register with frame-index dibit selection.
module lvds_tx_serializer
  import lvds_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  dibit_idx_t  idx,
  output logic [1:0]  dibit
);

  logic [31:0] shift_reg;

  // Hold the current sample word for the duration of its frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= word;
    end
  end

  // Select the dibit for the requested frame position
  always_comb begin
    dibit = frame_dibit(shift_reg, idx);
  end

endmodule

// File: rtl/lvds_tx.sv
// LVDS transmit serializer: pulls I/Q words from the TX FIFO and emits 16-dibit frames.
module lvds_tx
  import lvds_pkg::*;
(
  input  logic     i_ddr_clk,
  input  logic     i_reset,
  output logic     o_fifo_read_clk,
  lvds_tx_if.slave bus
);

  lvds_state_t state, state_n;
  dibit_idx_t  cnt, cnt_n;
  logic        pull, pull_n;
  logic        prefetch, prefetch_n;
  logic        underrun, underrun_n;
  logic        load;
  logic [1:0]  ddr, ddr_n;
  logic [1:0]  next_dibit;
  logic        can_pull;

  assign can_pull = bus.i_enable && !bus.i_fifo_empty;

  // Dibit for the next cycle comes from the frame position the counter moves to
  lvds_tx_serializer u_serializer (
    .clk   (i_ddr_clk),
    .rst   (i_reset),
    .load  (load),
    .word  (bus.i_fifo_data),
    .idx   (cnt_n),
    .dibit (next_dibit)
  );

  // Next-state, pull and counter logic
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pull_n     = 1'b0;
    prefetch_n = prefetch;
    underrun_n = underrun;
    load       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // The pull strobe is registered one cycle ahead, so the IDLE cycle that
        // shows it is the one that hands over to WAIT.
        if (pull) begin
          state_n = ST_WAIT;
        end else if (can_pull) begin
          pull_n = 1'b1;
        end
      end
      ST_WAIT: begin
        state_n = ST_TX;
        cnt_n   = '0;
        load    = 1'b1;
      end
      ST_TX: begin
        cnt_n = cnt + 1'b1;
        if (cnt == PULL_IDX && can_pull) begin
          pull_n     = 1'b1;
          prefetch_n = 1'b1;
        end
        if (cnt == LAST_IDX) begin
          if (prefetch) begin
            load       = 1'b1;
            prefetch_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
            pull_n  = can_pull;
            if (bus.i_enable) underrun_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (!bus.i_enable) underrun_n = 1'b0;
  end

  assign ddr_n = (state_n == ST_TX) ? next_dibit : IDLE_DIBIT;

  // State, counter and registered outputs
  always_ff @(posedge i_ddr_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pull     <= 1'b0;
      prefetch <= 1'b0;
      underrun <= 1'b0;
      ddr      <= IDLE_DIBIT;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pull     <= pull_n;
      prefetch <= prefetch_n;
      underrun <= underrun_n;
      ddr      <= ddr_n;
    end
  end

  assign o_fifo_read_clk = i_ddr_clk;
  assign bus.o_fifo_pull = pull;
  assign bus.o_ddr_data  = ddr;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_underrun  = underrun;

endmodule

// File: tb/tb_lvds_tx.sv
// Scoreboard bench for lvds_tx: FIFO model feeds words, monitor checks every output dibit.
module tb_lvds_tx;
  import lvds_pkg::*;

  logic clk;
  logic rst;
  logic read_clk;

  lvds_tx_if bus ();

  lvds_tx dut (
    .i_ddr_clk       (clk),
    .i_reset         (rst),
    .o_fifo_read_clk (read_clk),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];
  logic [1:0]  exp_q[$];
  logic [31:0] exp_words[$];
  logic [31:0] rx_log[$];
  int          pull_count = 0;

  int          cyc = 0;
  int          last_pull_cyc = -100;
  int          pos = 0;
  bit          in_frame = 1'b0;
  bit          prev_pull = 1'b0;
  int          chain = 0;
  int          last_chain = 0;
  int          frames_done = 0;
  logic [31:0] rx_word = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Reference model: frame content derived directly from the word layout
  function automatic void push_expected(input logic [31:0] w);
    int unsigned i_s;
    int unsigned q_s;
    i_s = (w >> 16) & 32'h3FFF;
    q_s = w & 32'h3FFF;
    exp_q.push_back(2'b10);
    for (int k = 0; k < 7; k++) exp_q.push_back(2'((i_s >> (12 - 2 * k)) & 3));
    exp_q.push_back(2'b01);
    for (int k = 0; k < 7; k++) exp_q.push_back(2'((q_s >> (12 - 2 * k)) & 3));
    exp_words.push_back((i_s << 16) | q_s);
  endfunction

  function automatic logic [31:0] rx_back(input int n);
    if (rx_log.size() < n) return 32'hDEADBEEF;
    return rx_log[rx_log.size() - n];
  endfunction

  // One clock of the FIFO model: a pull seen in a cycle yields data in the next one
  task automatic tick();
    logic p;
    @(negedge clk);
    p = bus.o_fifo_pull;
    @(posedge clk);
    #1;
    if (p && fifo_q.size() > 0) begin
      bus.i_fifo_data = fifo_q.pop_front();
      push_expected(bus.i_fifo_data);
      pull_count++;
    end
    bus.i_fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    bus.i_fifo_empty = 1'b0;
  endtask

  task automatic wait_sync(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_ddr_data == 2'b10) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(name, {31'b0, ok}, 32'd1);
  endtask

  // Monitor: compares every dibit against the scoreboard and decodes frames like the receiver
  always @(negedge clk) begin : monitor
    logic [1:0] d;
    cyc++;
    d = bus.o_ddr_data;
    if (rst) begin
      if (in_frame) begin
        for (int k = pos; k < 16; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_words.size() > 0) void'(exp_words.pop_front());
      end
      in_frame  = 1'b0;
      pos       = 0;
      prev_pull = 1'b0;
      chain     = 0;
    end else begin
      check("read_clk_follows_clk", {31'b0, read_clk}, 32'd0);
      if (bus.o_fifo_pull) begin
        check("pull_fifo_nonempty", {31'b0, bus.i_fifo_empty}, 32'd0);
        check("pull_not_consecutive", {31'b0, prev_pull}, 32'd0);
        last_pull_cyc = cyc;
      end
      prev_pull = bus.o_fifo_pull;
      if (!in_frame && d == 2'b10) begin
        check("frame_expected", 32'(exp_q.size()), 32'd16);
        check("sync_latency", 32'(cyc - last_pull_cyc), 32'd2);
        in_frame = 1'b1;
        pos      = 0;
        rx_word  = '0;
      end
      if (in_frame) begin
        check("busy_in_frame", {31'b0, bus.o_busy}, 32'd1);
        if (exp_q.size() > 0) check("frame_dibit", 32'(d), 32'(exp_q.pop_front()));
        rx_word = (rx_word << 2) | ((pos == 0 || pos == 8) ? 32'd0 : 32'(d));
        pos++;
        if (pos == 16) begin
          in_frame = 1'b0;
          frames_done++;
          chain++;
          rx_log.push_back(rx_word);
          if (exp_words.size() > 0) check("decoded_word", rx_word, exp_words.pop_front());
        end
      end else begin
        check("idle_dibit", 32'(d), 32'd0);
        if (chain > 0) last_chain = chain;
        chain = 0;
      end
    end
  end

  logic [1:0] s1_seq [16];
  int         base_pulls;
  int         base_frames;

  initial begin
    s1_seq = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01,
               2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    rst              = 1'b1;
    bus.i_enable     = 1'b0;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_data  = '0;
    run(2);
    check("reset_ddr", 32'(bus.o_ddr_data), 32'd0);
    check("reset_pull", {31'b0, bus.o_fifo_pull}, 32'd0);
    check("reset_busy", {31'b0, bus.o_busy}, 32'd0);
    check("reset_underrun", {31'b0, bus.o_underrun}, 32'd0);
    rst = 1'b0;
    run(2);

    // Single word, exact dibit sequence, then idle with underrun
    bus.i_enable = 1'b1;
    push_word(32'hA5A55A5A);
    wait_sync("s1_sync_seen");
    for (int k = 0; k < 16; k++) begin
      check("s1_sequence", 32'(bus.o_ddr_data), 32'(s1_seq[k]));
      tick();
    end
    check("s1_idle_after", 32'(bus.o_ddr_data), 32'd0);
    check("s1_underrun", {31'b0, bus.o_underrun}, 32'd1);
    run(5);
    check("s1_word", rx_back(1), 32'h25A51A5A);
    bus.i_enable = 1'b0;
    run(2);
    check("underrun_cleared", {31'b0, bus.o_underrun}, 32'd0);

    // Loopback pair, back to back
    bus.i_enable = 1'b1;
    push_word(32'hA5A55A5A);
    push_word(32'h3FFF0000);
    run(45);
    check("loop_word0", rx_back(2), 32'h25A51A5A);
    check("loop_word1", rx_back(1), 32'h3FFF0000);

    // Three words: one unbroken 48-dibit stream, exactly three pulls
    bus.i_enable = 1'b0;
    run(3);
    base_pulls = pull_count;
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    push_word(32'hFFFFFFFF);
    bus.i_enable = 1'b1;
    run(70);
    check("three_pulls", 32'(pull_count - base_pulls), 32'd3);
    check("three_chain", 32'(last_chain), 32'd3);

    // Empty FIFO with enable: nothing happens until a word arrives
    base_pulls = pull_count;
    run(10);
    check("empty_ddr_idle", 32'(bus.o_ddr_data), 32'd0);
    check("empty_no_pull", 32'(pull_count - base_pulls), 32'd0);
    check("empty_not_busy", {31'b0, bus.o_busy}, 32'd0);
    push_word(32'h2AAA1555);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.o_fifo_pull) begin
          seen = 1'b1;
          break;
        end
      end
      check("empty_pull_seen", {31'b0, seen}, 32'd1);
    end
    check("pull_cycle_not_busy", {31'b0, bus.o_busy}, 32'd0);
    tick();
    check("wait_busy", {31'b0, bus.o_busy}, 32'd1);
    check("wait_ddr_idle", 32'(bus.o_ddr_data), 32'd0);
    tick();
    check("sync_two_after_pull", 32'(bus.o_ddr_data), 32'd2);
    run(25);

    // Enable dropped at cnt==5: frame completes, no prefetch
    base_pulls  = pull_count;
    base_frames = frames_done;
    push_word(32'h1234ABCD);
    push_word(32'h0F0F0F0F);
    wait_sync("s5_sync_seen");
    run(5);
    bus.i_enable = 1'b0;
    run(20);
    check("drop_one_pull", 32'(pull_count - base_pulls), 32'd1);
    check("drop_frame_done", 32'(frames_done - base_frames), 32'd1);
    check("drop_underrun", {31'b0, bus.o_underrun}, 32'd0);
    check("drop_word_left", 32'(fifo_q.size()), 32'd1);
    fifo_q.delete();
    bus.i_fifo_empty = 1'b1;

    // Reset asserted mid-frame at cnt==9
    bus.i_enable = 1'b1;
    push_word(32'h3C3C3C3C);
    wait_sync("s6_sync_seen");
    run(9);
    #2;
    rst = 1'b1;
    #1;
    check("midreset_ddr", 32'(bus.o_ddr_data), 32'd0);
    check("midreset_pull", {31'b0, bus.o_fifo_pull}, 32'd0);
    check("midreset_busy", {31'b0, bus.o_busy}, 32'd0);
    tick();
    rst = 1'b0;
    base_frames = frames_done;
    push_word(32'h12345678);
    run(30);
    check("after_reset_frame", 32'(frames_done - base_frames), 32'd1);
    check("after_reset_word", rx_back(1), 32'h12341678);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) push_word($urandom());
      bus.i_enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    bus.i_enable = 1'b1;
    run(120);
    check("fifo_drained", 32'(fifo_q.size()), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("words_drained", 32'(exp_words.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
